inst_memory32: RTL and testbench

- Word-organised RV32 instruction memory feeding the fetch stage.
- Read is combinational and byte-addressed: PC in, 32-bit instruction out in the same cycle.
- Holds a fixed default boot image that is restored by reset.
- A clocked program-load port lets a bench or bootloader overwrite words.

---
 rtl/inst_mem_pkg.sv | 38 +++
 rtl/inst_memory32.sv | 73 +++++++
 tb/tb_inst_memory32.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/inst_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_pkg
//  Description : Shared constants and boot image for the RV32 instruction
//                memory. The CPU core and other clients import this package
//                so that everyone agrees on the NOP encoding and on the
//                default program loaded at reset.
//  Contents    : INST_W         - instruction width in bits
//                INST_NOP       - canonical NOP (addi x0,x0,0)
//                default_image  - boot word for a given word index
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_mem_pkg;

    localparam int unsigned INST_W = 32;

    localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

    // Boot program: computes x3 = 5 + 10, x4 = 10 - 5, stores x3 to address 0,
    // loads it back into x5, then spins on a branch-to-self. Every word past
    // the program is a NOP.
    function automatic logic [INST_W-1:0] default_image(input int unsigned idx);
        logic [INST_W-1:0] w_word;
        case (idx)
            0:       w_word = 32'h0050_0093;  // addi x1,x0,5
            1:       w_word = 32'h00A0_0113;  // addi x2,x0,10
            2:       w_word = 32'h0020_81B3;  // add  x3,x1,x2
            3:       w_word = 32'h4011_0233;  // sub  x4,x2,x1
            4:       w_word = 32'h0030_2023;  // sw   x3,0(x0)
            5:       w_word = 32'h0000_2283;  // lw   x5,0(x0)
            6:       w_word = 32'h0000_0063;  // beq  x0,x0,0
            default: w_word = INST_NOP;
        endcase
        return w_word;
    endfunction

endpackage : inst_mem_pkg
`default_nettype wire

// File: rtl/inst_memory32.sv
`default_nettype none
// ============================================================================
//  Module      : inst_memory32
//  Description : Word-organised RV32 instruction memory for the fetch stage.
//                Combinational, byte-addressed read; clocked program-load
//                port; synchronous active-low reset restores the boot image.
//  Ports       : clk        in   1  system clock, rising edge
//                rst_n      in   1  synchronous active-low reset
//                addr       in   N  fetch byte address (PC)
//                inst       out  N  instruction at addr (combinational)
//                misaligned out  1  addr[1:0] != 0 (combinational)
//                prog_we    in   1  program-load write enable
//                prog_addr  in   N  program-load byte address
//                prog_data  in   N  program-load data word
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_memory32
    import inst_mem_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] addr,
    output logic [N-1:0] inst,
    output logic         misaligned,
    input  logic         prog_we,
    input  logic [N-1:0] prog_addr,
    input  logic [N-1:0] prog_data
);

    // First byte address past the end of the array.
    localparam logic [N-1:0] c_BYTE_LIMIT = N'(DEPTH * 4);

    logic [N-1:0]  r_mem [DEPTH];

    logic [AW-1:0] w_rd_idx;
    logic          w_rd_in_range;
    logic [AW-1:0] w_wr_idx;
    logic          w_wr_ok;

    // ------------------------------------------------------------------------
    // Read path: purely combinational. The full address is range-checked so
    // that addresses beyond the array never alias onto low words; they read
    // back as NOP. The byte offset only drives the misaligned flag.
    // ------------------------------------------------------------------------
    assign w_rd_idx      = addr[AW+1:2];
    assign w_rd_in_range = (addr < c_BYTE_LIMIT);
    assign inst          = w_rd_in_range ? r_mem[w_rd_idx] : N'(INST_NOP);
    assign misaligned    = |addr[1:0];

    // ------------------------------------------------------------------------
    // Write qualification: only word-aligned, in-range writes land; anything
    // else is dropped without side effects.
    // ------------------------------------------------------------------------
    assign w_wr_idx = prog_addr[AW+1:2];
    assign w_wr_ok  = prog_we && (prog_addr[1:0] == 2'b00) && (prog_addr < c_BYTE_LIMIT);

    // Reset reloads every word and takes priority over a coincident write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= N'(default_image(i));
            end
        end else if (w_wr_ok) begin
            r_mem[w_wr_idx] <= prog_data;
        end
    end

endmodule : inst_memory32
`default_nettype wire

// File: tb/tb_inst_memory32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_memory32
//  Description : Directed self-checking bench for inst_memory32. Expected
//                values are hand-written constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_memory32;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        misaligned;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;

    int n_tests;
    int n_fail;

    logic [31:0] exp_boot [7];

    inst_memory32 #(
        .N     (32),
        .DEPTH (64)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .inst       (inst),
        .misaligned (misaligned),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Apply a read address, let it settle, and check both outputs.
    task automatic rd(input string tag, input logic [31:0] a,
                      input logic [31:0] exp_inst, input logic exp_mis);
        addr = a;
        #1;
        chk({tag, ".inst"}, inst, exp_inst);
        chk({tag, ".mis"}, {31'b0, misaligned}, {31'b0, exp_mis});
    endtask

    // Advance one rising edge, then step off it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_boot[0] = 32'h0050_0093;
        exp_boot[1] = 32'h00A0_0113;
        exp_boot[2] = 32'h0020_81B3;
        exp_boot[3] = 32'h4011_0233;
        exp_boot[4] = 32'h0030_2023;
        exp_boot[5] = 32'h0000_2283;
        exp_boot[6] = 32'h0000_0063;

        rst_n     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = 32'h0;
        prog_data = 32'h0;
        addr      = 32'h0;

        // Reset, then sweep words 0..19.
        tick();
        rst_n = 1'b1;
        for (int w = 0; w < 20; w++) begin
            rd($sformatf("sweep%0d", w), 32'(w * 4), (w < 7) ? exp_boot[w] : c_NOP, 1'b0);
        end

        // Misaligned reads return the containing word.
        rd("mis6", 32'd6, 32'h00A0_0113, 1'b1);
        rd("mis3", 32'd3, 32'h0050_0093, 1'b1);
        rd("mis255", 32'd255, c_NOP, 1'b1);

        // Range boundaries.
        rd("last252", 32'd252, c_NOP, 1'b0);
        rd("oor256", 32'd256, c_NOP, 1'b0);
        rd("oor264", 32'd264, c_NOP, 1'b0);
        rd("oorFFC", 32'hFFFF_FFFC, c_NOP, 1'b0);

        // Program load with read-during-write on the same word.
        prog_we   = 1'b1;
        prog_addr = 32'd8;
        prog_data = 32'hDEAD_BEEF;
        rd("rdw_before", 32'd8, 32'h0020_81B3, 1'b0);
        tick();
        prog_we = 1'b0;
        chk("rdw_after", inst, 32'hDEAD_BEEF);

        // Misaligned write is dropped.
        prog_we   = 1'b1;
        prog_addr = 32'd9;
        prog_data = 32'h1111_1111;
        tick();
        prog_we = 1'b0;
        rd("miswr_w2", 32'd8, 32'hDEAD_BEEF, 1'b0);
        rd("miswr_w3", 32'd12, 32'h4011_0233, 1'b0);

        // Out-of-range writes are dropped and never alias onto low words.
        prog_we   = 1'b1;
        prog_addr = 32'd256;
        prog_data = 32'h2222_2222;
        tick();
        prog_addr = 32'd264;
        prog_data = 32'h3333_3333;
        tick();
        prog_we = 1'b0;
        rd("oorwr_w0", 32'd0, 32'h0050_0093, 1'b0);
        rd("oorwr_w2", 32'd8, 32'hDEAD_BEEF, 1'b0);
        rd("oorwr_256", 32'd256, c_NOP, 1'b0);

        // Last valid word is writable.
        prog_we   = 1'b1;
        prog_addr = 32'd252;
        prog_data = 32'hCAFE_F00D;
        tick();
        prog_we = 1'b0;
        rd("lastwr", 32'd252, 32'hCAFE_F00D, 1'b0);
        rd("lastwr_w62", 32'd248, c_NOP, 1'b0);

        // Reset beats a coincident write and restores overwritten words.
        rst_n     = 1'b0;
        prog_we   = 1'b1;
        prog_addr = 32'd0;
        prog_data = 32'h1234_5678;
        tick();
        rst_n   = 1'b1;
        prog_we = 1'b0;
        rd("rstpri_w0", 32'd0, 32'h0050_0093, 1'b0);
        rd("rstpri_w2", 32'd8, 32'h0020_81B3, 1'b0);
        rd("rstpri_w63", 32'd252, c_NOP, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_inst_memory32
`default_nettype wire
